// File: rtl/input_conditioner_if.sv
`default_nettype none
// ============================================================================
//  Module   : input_conditioner_if
//  Brief    : Button pad / conditioned-output bundle for input_conditioner.
//  Revision : 1.0  initial release
// ============================================================================
interface input_conditioner_if #(
  parameter int NUM_CH = 4
);
  logic [NUM_CH-1:0] nIn;
  logic [NUM_CH-1:0] En;
  logic [NUM_CH-1:0] RepeatEn;
  logic [NUM_CH-1:0] Level;
  logic [NUM_CH-1:0] Press;
  logic [NUM_CH-1:0] Release;
  logic [NUM_CH-1:0] LongPress;
  logic [NUM_CH-1:0] Held;

  modport master (
    output nIn, En, RepeatEn,
    input  Level, Press, Release, LongPress, Held
  );

  modport slave (
    input  nIn, En, RepeatEn,
    output Level, Press, Release, LongPress, Held
  );
endinterface
`default_nettype wire

// File: rtl/input_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : input_conditioner
//  Brief    : Per-channel button synchroniser, debouncer, edge pulses,
//             long-press detection and auto-repeat.
//  Revision : 1.0  initial release
// ============================================================================
module input_conditioner #(
  parameter int NUM_CH          = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int LONG_CYCLES     = 1024,
  parameter int REPEAT_CYCLES   = 256
) (
  input  wire logic          HCLK,
  input  wire logic          HRESETn,
  input_conditioner_if.slave bus
);

  localparam int c_MAX_DL = (DEBOUNCE_CYCLES > LONG_CYCLES) ? DEBOUNCE_CYCLES : LONG_CYCLES;
  localparam int c_MAX    = (c_MAX_DL > REPEAT_CYCLES) ? c_MAX_DL : REPEAT_CYCLES;
  localparam int CNT_W    = $clog2(c_MAX + 1);

  localparam logic [CNT_W-1:0] c_DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_ONE       = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_REL     = 2'd0,
    ST_PRESSED = 2'd1,
    ST_LONG    = 2'd2
  } state_t;

  logic [NUM_CH-1:0] w_level;
  logic [NUM_CH-1:0] w_press;
  logic [NUM_CH-1:0] w_release;
  logic [NUM_CH-1:0] w_long;
  logic [NUM_CH-1:0] w_held;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       r_hcnt;
    state_t                 r_state;
    logic                   r_level;
    logic                   r_press;
    logic                   r_release;
    logic                   r_long;
    logic                   r_held;
    logic                   w_s;
    logic                   w_accept;
    logic                   w_acc_press;
    logic                   w_acc_rel;

    // Pads idle high, so the chain presets to "released".
    always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
        r_sync <= '1;
      end else begin
        r_sync <= {r_sync[SYNC_STAGES-2:0], bus.nIn[gi]};
      end
    end

    assign w_s         = ~r_sync[SYNC_STAGES-1];
    assign w_accept    = (w_s != r_level) && (r_cnt == c_DB_LAST);
    assign w_acc_press = w_accept & w_s;
    assign w_acc_rel   = w_accept & ~w_s;

    always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
        r_cnt     <= '0;
        r_hcnt    <= '0;
        r_state   <= ST_REL;
        r_level   <= 1'b0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
        r_long    <= 1'b0;
        r_held    <= 1'b0;
      end else begin
        r_press   <= 1'b0;
        r_release <= 1'b0;
        r_long    <= 1'b0;
        if (!bus.En[gi]) begin
          r_cnt   <= '0;
          r_hcnt  <= '0;
          r_state <= ST_REL;
          r_level <= 1'b0;
          r_held  <= 1'b0;
        end else begin
          if (w_s != r_level) begin
            if (r_cnt == c_DB_LAST) begin
              r_level   <= w_s;
              r_cnt     <= '0;
              r_press   <= w_s;
              r_release <= ~w_s;
            end else begin
              r_cnt <= r_cnt + c_ONE;
            end
          end else begin
            r_cnt <= '0;
          end

          // A release accepted on a threshold cycle takes priority.
          case (r_state)
            ST_REL: begin
              if (w_acc_press) begin
                r_state <= ST_PRESSED;
                r_hcnt  <= '0;
              end
            end
            ST_PRESSED: begin
              if (w_acc_rel) begin
                r_state <= ST_REL;
                r_hcnt  <= '0;
                r_held  <= 1'b0;
              end else if (r_hcnt == c_LONG_LAST) begin
                r_long  <= 1'b1;
                r_held  <= 1'b1;
                r_state <= ST_LONG;
                r_hcnt  <= '0;
              end else begin
                r_hcnt <= r_hcnt + c_ONE;
              end
            end
            ST_LONG: begin
              if (w_acc_rel) begin
                r_state <= ST_REL;
                r_hcnt  <= '0;
                r_held  <= 1'b0;
              end else if (!bus.RepeatEn[gi]) begin
                r_hcnt <= '0;
              end else if (r_hcnt == c_REP_LAST) begin
                r_long <= 1'b1;
                r_hcnt <= '0;
              end else begin
                r_hcnt <= r_hcnt + c_ONE;
              end
            end
            default: begin
              r_state <= ST_REL;
              r_hcnt  <= '0;
              r_held  <= 1'b0;
            end
          endcase
        end
      end
    end

    assign w_level[gi]   = r_level;
    assign w_press[gi]   = r_press;
    assign w_release[gi] = r_release;
    assign w_long[gi]    = r_long;
    assign w_held[gi]    = r_held;
  end

  assign bus.Level     = w_level;
  assign bus.Press     = w_press;
  assign bus.Release   = w_release;
  assign bus.LongPress = w_long;
  assign bus.Held      = w_held;

endmodule
`default_nettype wire

// File: tb/tb_input_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_input_conditioner
//  Brief    : Scoreboard bench; reference model predicts pulse events and
//             Level/Held from the behavioural rules, monitor compares.
//  Revision : 1.0  initial release
// ============================================================================
module tb_input_conditioner;

  localparam int NCH = 4;
  localparam int SS  = 2;
  localparam int DB  = 16;
  localparam int LP  = 1024;
  localparam int RP  = 256;

  typedef struct {
    int cyc;
    int ch;
    int kind;
  } ev_t;

  logic HCLK;
  logic HRESETn;

  input_conditioner_if #(.NUM_CH(NCH)) bus ();

  input_conditioner #(
    .NUM_CH          (NCH),
    .SYNC_STAGES     (SS),
    .DEBOUNCE_CYCLES (DB),
    .LONG_CYCLES     (LP),
    .REPEAT_CYCLES   (RP)
  ) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus)
  );

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  ev_t exp_q[$];

  // Reference model state: m_st 0=idle, 1=held down, 2=past long threshold.
  logic [NCH-1:0] m_pipe[$];
  logic [NCH-1:0] m_old;
  logic [NCH-1:0] m_lvl;
  logic [NCH-1:0] m_held;
  int  m_run [NCH];
  int  m_st  [NCH];
  int  m_t0  [NCH];
  int  m_ref [NCH];
  bit  ms, map, mar;

  function automatic string kname(int k);
    return (k == 0) ? "Press" : (k == 1) ? "Release" : "LongPress";
  endfunction

  task automatic push_ev(int c, int k);
    ev_t e;
    e.cyc = cyc; e.ch = c; e.kind = k;
    exp_q.push_back(e);
  endtask

  task automatic model_reset();
    m_pipe.delete();
    for (int i = 0; i < SS; i++) m_pipe.push_back('1);
    m_lvl  = '0;
    m_held = '0;
    for (int c = 0; c < NCH; c++) begin
      m_run[c] = 0; m_st[c] = 0; m_t0[c] = 0; m_ref[c] = 0;
    end
  endtask

  always @(posedge HCLK) begin
    cyc++;
    if (!HRESETn) begin
      model_reset();
    end else begin
      m_old = m_pipe.pop_front();
      m_pipe.push_back(bus.nIn);
      for (int c = 0; c < NCH; c++) begin
        ms = ~m_old[c];
        if (!bus.En[c]) begin
          m_lvl[c] = 1'b0; m_held[c] = 1'b0; m_run[c] = 0; m_st[c] = 0;
        end else begin
          map = 1'b0; mar = 1'b0;
          if (ms != m_lvl[c]) begin
            m_run[c]++;
            if (m_run[c] == DB) begin
              m_lvl[c] = ms; m_run[c] = 0; map = ms; mar = ~ms;
            end
          end else begin
            m_run[c] = 0;
          end
          if (map) push_ev(c, 0);
          if (mar) push_ev(c, 1);
          if (m_st[c] == 0) begin
            if (map) begin m_st[c] = 1; m_t0[c] = cyc; end
          end else if (mar) begin
            m_st[c] = 0; m_held[c] = 1'b0;
          end else if (m_st[c] == 1) begin
            if (cyc - m_t0[c] == LP) begin
              push_ev(c, 2); m_st[c] = 2; m_held[c] = 1'b1; m_ref[c] = cyc;
            end
          end else begin
            if (!bus.RepeatEn[c]) m_ref[c] = cyc;
            else if (cyc - m_ref[c] == RP) begin
              push_ev(c, 2); m_ref[c] = cyc;
            end
          end
        end
      end
    end
  end

  // Monitor: compares observed pulses against the expected-event queue.
  logic [NCH-1:0] mon_pv [3];
  always @(posedge HCLK) begin
    #1;
    mon_pv[0] = bus.Press; mon_pv[1] = bus.Release; mon_pv[2] = bus.LongPress;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      checks++; errors++;
      $display("FAIL missed %s ch%0d cycle %0d: got 0 required 1",
               kname(exp_q[0].kind), exp_q[0].ch, exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
    for (int c = 0; c < NCH; c++) begin
      for (int k = 0; k < 3; k++) begin
        if (mon_pv[k][c]) begin
          checks++;
          if (exp_q.size() > 0 && exp_q[0].cyc == cyc && exp_q[0].ch == c && exp_q[0].kind == k) begin
            void'(exp_q.pop_front());
          end else begin
            errors++;
            $display("FAIL spurious %s ch%0d cycle %0d: got 1 required 0", kname(k), c, cyc);
          end
        end
      end
    end
    while (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      checks++; errors++;
      $display("FAIL missed %s ch%0d cycle %0d: got 0 required 1",
               kname(exp_q[0].kind), exp_q[0].ch, exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
    checks++;
    if (bus.Level !== m_lvl) begin
      errors++;
      $display("FAIL Level cycle %0d: got %b required %b", cyc, bus.Level, m_lvl);
    end
    checks++;
    if (bus.Held !== m_held) begin
      errors++;
      $display("FAIL Held cycle %0d: got %b required %b", cyc, bus.Held, m_held);
    end
  end

  task automatic step(int n);
    repeat (n) @(negedge HCLK);
  endtask

  int rem [NCH];

  initial begin
    model_reset();
    HRESETn      = 1'b0;
    bus.nIn      = '0;
    bus.En       = '1;
    bus.RepeatEn = '0;
    step(5);
    HRESETn = 1'b1;
    bus.nIn = 4'b1110;
    step(40);
    bus.nIn[0] = 1'b1;
    step(40);

    // 15-sample glitch must vanish, 16 samples must be accepted.
    bus.nIn[1] = 1'b0; step(15);
    bus.nIn[1] = 1'b1; step(30);
    bus.nIn[1] = 1'b0; step(16);
    bus.nIn[1] = 1'b1; step(40);

    bus.RepeatEn[2] = 1'b1;
    bus.nIn[2] = 1'b0; step(1900);
    bus.nIn[2] = 1'b1; step(40);
    bus.RepeatEn[2] = 1'b0;
    bus.nIn[2] = 1'b0; step(1500);
    bus.nIn[2] = 1'b1; step(40);

    bus.nIn[3] = 1'b0; step(40);
    bus.En[3]  = 1'b0; step(5);
    bus.En[3]  = 1'b1; step(40);
    bus.nIn[3] = 1'b1; step(40);

    bus.nIn = '0; step(SS + DB + 500);
    HRESETn = 1'b0; step(3);
    HRESETn = 1'b1; step(1200);
    bus.nIn = '1; step(40);

    for (int c = 0; c < NCH; c++) rem[c] = 0;
    for (int n = 0; n < 20000; n++) begin
      for (int c = 0; c < NCH; c++) begin
        if (rem[c] == 0) begin
          bus.nIn[c] = 1'($urandom_range(0, 1));
          rem[c] = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 20))
                                               : int'($urandom_range(20, 1400));
        end
        rem[c]--;
        if ($urandom_range(0, 599) == 0) bus.En[c] = ~bus.En[c];
        if ($urandom_range(0, 399) == 0) bus.RepeatEn[c] = ~bus.RepeatEn[c];
      end
      step(1);
    end

    bus.nIn = '1;
    bus.En  = '1;
    step(60);
    while (exp_q.size() > 0) begin
      checks++; errors++;
      $display("FAIL missed %s ch%0d cycle %0d: got 0 required 1",
               kname(exp_q[0].kind), exp_q[0].ch, exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
